// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM states, SPI mode codes
// ({cpol,cpha}) and the chip-select index width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // cs_sel needs at least one bit even for a single slave
  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: counts 0..Nt-1 while enabled, tick on Nt-1.
// Ports: clk, rst_n (sync, active low), i_en, i_clr, o_tick.
module spi_clk_div #(
  parameter int Nt = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(Nt);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(Nt - 1));
  assign o_tick = i_en & w_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// SPI master, all four modes, MSB/LSB first, one-hot active-low selects.
// Ports: clk, rst_n, st/DI/cs_sel/cpol/cpha/lsb_first (request), MISO,
// SCLK/MOSI/CS_N (bus), busy/done/DO (status and received word).
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int m   = 9,
  parameter int Nt  = 100,
  parameter int NCS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st,
  input  logic [m-1:0]               DI,
  input  logic [cs_width(NCS)-1:0]   cs_sel,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic                       lsb_first,
  input  logic                       MISO,
  output logic                       SCLK,
  output logic                       MOSI,
  output logic [NCS-1:0]             CS_N,
  output logic                       busy,
  output logic                       done,
  output logic [m-1:0]               DO
);

  localparam int EW = $clog2(2 * m + 1);

  state_t         r_state;
  logic           r_sclk;
  logic           r_mosi;
  logic [NCS-1:0] r_cs_n;
  logic           r_busy;
  logic           r_done;
  logic [m-1:0]   r_do;
  logic           r_cpol;
  logic           r_cpha;
  logic           r_lsb;
  logic [m-1:0]   r_tx;
  logic [m-1:0]   r_rx;
  logic [EW-1:0]  r_e;

  logic           w_tick;
  logic           w_accept;
  logic [NCS-1:0] w_cs_dec;
  logic [EW-1:0]  w_e_nxt;
  logic           w_sample;
  logic           w_last_edge;
  logic           w_head;
  logic [m-1:0]   w_tx_sh;
  logic [m-1:0]   w_rx_nxt;

  assign w_accept = (r_state == IDLE) && st;

  spi_clk_div #(
    .Nt(Nt)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_state != IDLE),
    .i_clr (w_accept),
    .o_tick(w_tick)
  );

  // out-of-range index leaves every select high
  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NCS; i++) begin
      if (int'(cs_sel) == i) w_cs_dec[i] = 1'b0;
    end
  end

  // odd edge count = leading edge; cpha flips which edge samples
  assign w_e_nxt     = r_e + 1'b1;
  assign w_sample    = w_e_nxt[0] ^ r_cpha;
  assign w_last_edge = (w_e_nxt == EW'(2 * m));
  assign w_head      = r_lsb ? r_tx[0] : r_tx[m-1];
  assign w_tx_sh     = r_lsb ? (r_tx >> 1) : (r_tx << 1);
  assign w_rx_nxt    = r_lsb ? {MISO, r_rx[m-1:1]}
                             : {r_rx[m-2:0], MISO};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_lsb   <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_e     <= '0;
      // an aborted transfer keeps the last completed word
      if (!r_busy) r_do <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cpol <= cpol;
          r_sclk <= cpol;
          r_busy <= st;
          if (st) begin
            r_state <= LEAD;
            r_cs_n  <= w_cs_dec;
            r_cpha  <= cpha;
            r_lsb   <= lsb_first;
            r_rx    <= '0;
            r_e     <= '0;
            if (!cpha) begin
              r_mosi <= lsb_first ? DI[0] : DI[m-1];
              r_tx   <= lsb_first ? (DI >> 1) : (DI << 1);
            end else begin
              r_mosi <= 1'b0;
              r_tx   <= DI;
            end
          end
        end
        LEAD: begin
          if (w_tick) r_state <= XFER;
        end
        XFER: begin
          if (w_tick) begin
            r_e <= w_e_nxt;
            if (w_sample) begin
              r_rx <= w_rx_nxt;
            end else if (!w_last_edge) begin
              r_mosi <= w_head;
              r_tx   <= w_tx_sh;
            end
            if (w_last_edge) begin
              r_sclk  <= r_cpol;
              r_state <= TRAIL;
            end else begin
              r_sclk <= ~r_sclk;
            end
          end
        end
        TRAIL: begin
          if (w_tick) begin
            r_do    <= r_rx;
            r_done  <= 1'b1;
            r_cs_n  <= '1;
            r_mosi  <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign SCLK = r_sclk;
  assign MOSI = r_mosi;
  assign CS_N = r_cs_n;
  assign busy = r_busy;
  assign done = r_done;
  assign DO   = r_do;

endmodule

// File: tb/tb_spi_master_gen.sv
// Scoreboard bench for spi_master_gen with a behavioural SPI slave.
// Driver queues expected transfers; monitor checks every cycle.
module tb_spi_master_gen;
  import spi_pkg::*;

  localparam int M   = 9;
  localparam int NT  = 4;
  localparam int NC  = 4;
  localparam int LAT = (2 * M + 2) * NT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st = 1'b0;
  logic [M-1:0]  DI = '0;
  logic [1:0]    cs_sel = '0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          lsb_first = 1'b0;
  logic          MISO;
  logic          SCLK;
  logic          MOSI;
  logic [NC-1:0] CS_N;
  logic          busy;
  logic          done;
  logic [M-1:0]  DO;

  spi_master_gen #(
    .m  (M),
    .Nt (NT),
    .NCS(NC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st       (st),
    .DI       (DI),
    .cs_sel   (cs_sel),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsb_first(lsb_first),
    .MISO     (MISO),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .CS_N     (CS_N),
    .busy     (busy),
    .done     (done),
    .DO       (DO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           acc;
    logic [M-1:0] di;
    logic [M-1:0] rx_exp;
    logic         cpol;
    logic         cpha;
    logic [1:0]   cs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic [M-1:0] last_do = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NC-1:0] cs_dec(input logic [1:0] s);
    logic [NC-1:0] r;
    r = '1;
    r[s] = 1'b0;
    return r;
  endfunction

  function automatic logic tx_bit(input logic [M-1:0] w, input int k,
                                  input logic lsb);
    if (k >= M) return 1'b0;
    return lsb ? w[k] : w[M-1-k];
  endfunction

  // slave: word in/out in transfer order, counts SCLK rises and
  // MOSI changes that land on the wrong SCLK edge
  logic         s_miso = 1'b0;
  logic         loop = 1'b0;
  logic [M-1:0] cur_resp = '0;
  logic         cur_cpol = 1'b0;
  logic         cur_cpha = 1'b0;
  logic         cur_lsb = 1'b0;
  logic [M-1:0] s_rx = '0;
  int           s_ib = 0;
  int           s_ob = 0;
  int           s_rises = 0;
  int           s_misalign = 0;
  logic         p_act = 1'b0;
  logic         p_sclk = 1'b0;
  logic         p_mosi = 1'b0;

  assign MISO = loop ? MOSI : s_miso;

  always @(posedge clk) begin
    logic act;
    logic lead;
    #1;
    act = (CS_N != {NC{1'b1}});
    if (act && !p_act) begin
      s_rx = '0;
      s_ib = 0;
      s_ob = 0;
      s_rises = 0;
      s_misalign = 0;
      if (!cur_cpha) begin
        s_miso = tx_bit(cur_resp, 0, cur_lsb);
        s_ob = 1;
      end
    end else if (act && p_act) begin
      lead = (SCLK != cur_cpol);
      if (MOSI != p_mosi &&
          !(SCLK != p_sclk && lead == cur_cpha))
        s_misalign++;
      if (SCLK != p_sclk) begin
        if (!p_sclk) s_rises++;
        if (lead != cur_cpha) begin
          if (s_ib < M) begin
            if (cur_lsb) s_rx[s_ib] = MOSI;
            else s_rx[M-1-s_ib] = MOSI;
          end
          s_ib++;
        end else begin
          s_miso = tx_bit(cur_resp, s_ob, cur_lsb);
          s_ob++;
        end
      end
    end
    p_act = act;
    p_sclk = SCLK;
    p_mosi = MOSI;
  end

  // monitor: compares outputs against the head of the queue
  always @(posedge clk) begin
    exp_t e;
    logic busy_x;
    logic cs_low;
    logic done_x;
    #1;
    if (mon_en) begin
      busy_x = 1'b0;
      cs_low = 1'b0;
      done_x = 1'b0;
      if (q.size() > 0) begin
        e = q[0];
        busy_x = (cyc >= e.acc) && (cyc <= e.acc + LAT);
        cs_low = (cyc >= e.acc) && (cyc < e.acc + LAT);
        done_x = (cyc == e.acc + LAT);
        if (cyc == e.acc) chk("sclk_idle", 32'(SCLK), 32'(e.cpol));
      end
      chk("busy", 32'(busy), 32'(busy_x));
      chk("done", 32'(done), 32'(done_x));
      chk("cs_n", 32'(CS_N),
          cs_low ? 32'(cs_dec(e.cs)) : 32'({NC{1'b1}}));
      if (done_x) begin
        chk("do", 32'(DO), 32'(e.rx_exp));
        chk("slave_rx", 32'(s_rx), 32'(e.di));
        chk("sclk_rises", 32'(s_rises), 32'(M));
        chk("mosi_align", 32'(s_misalign), 32'd0);
        chk("sclk_end", 32'(SCLK), 32'(e.cpol));
        last_do = e.rx_exp;
        void'(q.pop_front());
      end else begin
        chk("do_hold", 32'(DO), 32'(last_do));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() > 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL idle_timeout: got busy=%0b expected idle", busy);
    end
  endtask

  task automatic start(input logic [M-1:0] di, input logic [1:0] mode,
                       input logic lsb, input logic [1:0] cs,
                       input logic [M-1:0] resp, input logic lp,
                       input bit hold, output int acc);
    exp_t e;
    wait_idle();
    cur_cpol = mode[1];
    cur_cpha = mode[0];
    cur_lsb = lsb;
    cur_resp = resp;
    loop = lp;
    DI = di;
    cpol = mode[1];
    cpha = mode[0];
    lsb_first = lsb;
    cs_sel = cs;
    st = 1'b1;
    acc = cyc + 1;
    e.acc = acc;
    e.di = di;
    e.rx_exp = lp ? di : resp;
    e.cpol = mode[1];
    e.cpha = mode[0];
    e.cs = cs;
    q.push_back(e);
    if (!hold) begin
      @(negedge clk);
      st = 1'b0;
      DI = M'($urandom);
      cpol = 1'($urandom);
      cpha = 1'($urandom);
      lsb_first = 1'($urandom);
      cs_sel = 2'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    exp_t e2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_cs_n", 32'(CS_N), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_do", 32'(DO), 32'd0);
    mon_en = 1'b1;

    start(9'h1A5, SPI_MODE0, 1'b0, 2'd0, 9'h000, 1'b1, 1'b0, a);

    start(M'($urandom), SPI_MODE0, 1'b0, 2'd0, 9'h0F3, 1'b0, 1'b0, a);
    start(M'($urandom), SPI_MODE1, 1'b0, 2'd0, 9'h0F3, 1'b0, 1'b0, a);
    start(M'($urandom), SPI_MODE2, 1'b0, 2'd0, 9'h0F3, 1'b0, 1'b0, a);
    start(M'($urandom), SPI_MODE3, 1'b0, 2'd0, 9'h0F3, 1'b0, 1'b0, a);

    start(9'h001, SPI_MODE0, 1'b1, 2'd0, 9'h000, 1'b1, 1'b0, a);

    start(M'($urandom), SPI_MODE1, 1'b0, 2'd2, M'($urandom), 1'b0,
          1'b0, a);
    repeat (20) @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;

    // abort at the 7th SCLK edge
    start(M'($urandom), SPI_MODE0, 1'b0, 2'd1, M'($urandom), 1'b0,
          1'b0, a);
    while (cyc < a + NT + 7 * NT - 1) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_cs_n", 32'(CS_N), 32'hF);
    chk("abort_sclk", 32'(SCLK), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_do", 32'(DO), 32'(last_do));
    repeat (LAT) @(negedge clk);

    // st held high: second transfer one cycle after the first done
    start(M'($urandom), SPI_MODE3, 1'b1, 2'd3, M'($urandom), 1'b0,
          1'b1, a);
    e2 = q[q.size()-1];
    e2.acc = a + LAT + 1;
    q.push_back(e2);
    while (cyc < a + LAT + 1) @(negedge clk);
    st = 1'b0;

    for (int i = 0; i < 20; i++) begin
      start(M'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
            M'($urandom), 1'($urandom), 1'b0, a);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
